// File: rtl/sw_debounce.sv
// Per-bit switch debouncer feeding the slide-switch PIO in_port.
// A new level is accepted only after it holds for STABLE_TICKS ticks.
module sw_debounce #(
  parameter int WIDTH        = 10,
  parameter int PRESCALE     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_changed,
  output logic             tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    pcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  assign tick = (pcnt == PLAST);

  // Free-running, shared by every channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic          db;
    logic          chg;
    logic [CW-1:0] cnt;
    logic          match;
    logic          upd;
    logic          inc;

    assign match = (s2[g] == db);
    assign upd   = !match && tick && (cnt == CLAST);
    assign inc   = !match && tick && (cnt != CLAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db  <= 1'b0;
        chg <= 1'b0;
        cnt <= '0;
      end else begin
        chg <= 1'b0;
        unique case (1'b1)
          match: cnt <= '0;
          upd: begin
            db  <= s2[g];
            chg <= 1'b1;
            cnt <= '0;
          end
          inc:     cnt <= cnt + 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign sw_db[g]      = db;
    assign sw_changed[g] = chg;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: vector table, window-based reference model
// and directed multi-cycle sequences across three parameter sets.
module tb_sw_debounce;

  localparam int W    = 10;
  localparam int ST_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rn_a = 1'b0, rn_b = 1'b0, rn_c = 1'b0;
  logic [W-1:0] raw_a = '0, raw_b = '0, raw_c = '0;
  logic [W-1:0] db_a, chg_a, db_b, chg_b, db_c, chg_c;
  logic         tick_a, tick_b, tick_c;

  sw_debounce #(.WIDTH(W), .PRESCALE(1), .STABLE_TICKS(ST_A)) u_a (
    .clk(clk), .reset_n(rn_a), .sw_raw(raw_a),
    .sw_db(db_a), .sw_changed(chg_a), .tick(tick_a)
  );

  sw_debounce #(.WIDTH(W), .PRESCALE(5), .STABLE_TICKS(3)) u_b (
    .clk(clk), .reset_n(rn_b), .sw_raw(raw_b),
    .sw_db(db_b), .sw_changed(chg_b), .tick(tick_b)
  );

  sw_debounce #(.WIDTH(W), .PRESCALE(1), .STABLE_TICKS(8)) u_c (
    .clk(clk), .reset_n(rn_c), .sw_raw(raw_c),
    .sw_db(db_c), .sw_changed(chg_c), .tick(tick_c)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: a bit flips when the synchronised level has differed
  // from the accepted level for the last ST_A samples in a row.
  logic [W-1:0] m_raw_q[$];
  logic [W-1:0] m_s2_q[$];
  logic [W-1:0] m_db;
  logic [W-1:0] m_chg;

  task automatic model_reset();
    m_raw_q.delete();
    m_s2_q.delete();
    m_db  = '0;
    m_chg = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] flip;
    logic [W-1:0] s2n;
    bit           all;
    int           n;
    flip = '0;
    n    = m_s2_q.size();
    if (n >= ST_A) begin
      for (int b = 0; b < W; b++) begin
        all = 1;
        for (int k = 1; k <= ST_A; k++)
          if (m_s2_q[n-k][b] == m_db[b]) all = 0;
        flip[b] = all;
      end
    end
    m_raw_q.push_back(r);
    s2n = '0;
    if (m_raw_q.size() >= 2) s2n = m_raw_q[m_raw_q.size()-2];
    m_s2_q.push_back(s2n);
    while (m_raw_q.size() > 4) m_raw_q.delete(0);
    while (m_s2_q.size() > 16) m_s2_q.delete(0);
    m_db  = m_db ^ flip;
    m_chg = flip;
  endtask

  task automatic step_a(input logic [W-1:0] r);
    raw_a = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("model_db", db_a, m_db);
    check("model_chg", chg_a, m_chg);
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] db;
    logic [W-1:0] chg;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           pulses;
    int           pulse_at;
    int           upd;
    int           nt;
    logic         pt;
    logic         upd_tick;
    logic [W-1:0] upd_db;
    logic [W-1:0] upd_chg;
    logic [W-1:0] r;
    int           k;

    // Clean step on bit 0, then a 3-cycle glitch on bit 3.
    for (int i = 0; i < 16; i++) begin
      tbl[i].raw = (i >= 7 && i <= 9) ? 10'h009 : 10'h001;
      tbl[i].db  = (i >= 5) ? 10'h001 : 10'h000;
      tbl[i].chg = (i == 5) ? 10'h001 : 10'h000;
    end

    // Reset held with all switches high.
    raw_a = 10'h3FF;
    raw_b = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_db", db_a, 10'h000);
      check("rst_chg", chg_a, 10'h000);
      check("rst_tick_p1", {31'b0, tick_a}, 1);
      check("rst_tick_p5", {31'b0, tick_b}, 0);
      check("rst_db_b", db_b, 10'h000);
    end

    // Switches high at power-up: one pulse after validation.
    rn_a = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step_a(10'h3FF);
    check("powerup_db", db_a, 10'h3FF);
    for (int i = 0; i < 8; i++) step_a(10'h000);
    check("powerdown_db", db_a, 10'h000);

    rn_a = 1'b0;
    @(posedge clk);
    #1;
    rn_a = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      raw_a = tbl[i].raw;
      @(posedge clk);
      model_edge(tbl[i].raw);
      #1;
      check($sformatf("tbl%0d_db", i), db_a, tbl[i].db);
      check($sformatf("tbl%0d_chg", i), chg_a, tbl[i].chg);
      check($sformatf("tbl%0d_mdl", i), db_a, m_db);
    end

    // Bounce on bit 5, then settle high.
    pulses   = 0;
    pulse_at = -1;
    for (int i = 1; i <= 16; i++) begin
      r = raw_a;
      r[5] = (i <= 5) ? ((i % 2) == 1) : 1'b1;
      step_a(r);
      if (chg_a[5]) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_pulse_edge", pulse_at, 10);
    check("bounce_db5", {31'b0, db_a[5]}, 1);

    // Random activity against the reference model.
    r = raw_a;
    for (int blk = 0; blk < 8; blk++) begin
      k = $urandom_range(2, 12);
      for (int i = 0; i < 50; i++) begin
        for (int b = 0; b < W; b++)
          if ($urandom_range(0, k) == 0) r[b] = ~r[b];
        step_a(r);
      end
    end

    // Prescaled, all channels at once.
    raw_b = '0;
    @(posedge clk);
    #1;
    rn_b = 1'b1;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (tick_b) nt++;
    end
    check("b_tick_rate", nt, 4);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
    raw_b    = 10'h2A5;
    upd      = -1;
    upd_tick = 1'b0;
    upd_db   = '0;
    upd_chg  = '0;
    for (int n = 1; n <= 40 && upd < 0; n++) begin
      pt = tick_b;
      @(posedge clk);
      #1;
      if (chg_b != '0 || db_b != '0) begin
        upd      = n;
        upd_tick = pt;
        upd_db   = db_b;
        upd_chg  = chg_b;
      end
    end
    check("b_update_seen", 32'(upd > 0), 1);
    check("b_latency_range", 32'(upd >= 12 && upd <= 18), 1);
    check("b_on_tick", {31'b0, upd_tick}, 1);
    check("b_db", upd_db, 10'h2A5);
    check("b_chg", upd_chg, 10'h2A5);
    @(posedge clk);
    #1;
    check("b_chg_after", chg_b, 10'h000);
    check("b_db_after", db_b, 10'h2A5);

    // Reset in the middle of validation.
    rn_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    raw_c = 10'h200;
    repeat (5) @(posedge clk);
    #1;
    rn_c = 1'b0;
    #1;
    check("c_db_in_rst", db_c, 10'h000);
    repeat (2) @(posedge clk);
    #1;
    check("c_db_in_rst2", db_c, 10'h000);
    check("c_chg_in_rst", chg_c, 10'h000);
    rn_c = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (n == 9) check("c_db_e9", {31'b0, db_c[9]}, 0);
      if (n == 10) begin
        check("c_db_e10", {31'b0, db_c[9]}, 1);
        check("c_chg_e10", chg_c, 10'h200);
      end
      if (n == 11) check("c_chg_e11", chg_c, 10'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
